kernel_conv_mac: RTL and testbench
==================================

// Module: kernel_conv_mac
// PURPOSE
//  Consumes the SIZE x SIZE 8-bit Gaussian kernel built by CreateKernel and applies it to one window.
//  Takes one SIZE x SIZE 8-bit pixel window per transaction. Outputs the normalised weighted average
//  as one 8-bit pixel: round(sum(k*p) / sum(k)). Sequential core: one MAC per cycle, then a 1-bit/cycle divide.
//  Sits between the window/line-buffer stage (upstream) and the FAST corner scorer (downstream).
// PARAMETERS
//  SIZE   4'd7   kernel/window edge length; legal range 3..15, odd
//  N      (localparam) SIZE*SIZE, number of taps
//  ACC_W  (localparam) 16+$clog2(N)+1, accumulator width; also the number of divide cycles
// PORTS
//  clk         in   1                    system clock, rising edge
//  n_rst       in   1                    reset, synchronous, active-low
//  kernel      in   [SIZE-1:0][SIZE-1:0][7:0]  weights, same packing as CreateKernel.kernel
//  kernel_err  in   1                    CreateKernel.err; sampled at accept
//  window      in   [SIZE-1:0][SIZE-1:0][7:0]  pixels; window[r][c] aligns with kernel[r][c]
//  in_valid    in   1                    window+kernel valid
//  in_ready    out  1                    block can accept
//  out_pixel   out  8                    filtered pixel
//  out_err     out  1                    result invalid (zero weight sum or kernel_err)
//  out_valid   out  1                    result valid
//  out_ready   in   1                    consumer takes result
// BEHAVIOUR
//  - Reset: an edge with n_rst=0 forces state IDLE and clears out_valid, out_err, out_pixel and the accumulators.
//    Any transaction in flight is dropped, with no output. in_ready=1 from the first cycle in IDLE.
//  - States: IDLE -> MAC -> DIV -> DONE -> IDLE.
//  - in_ready = (state==IDLE), combinational from state. A transfer is an edge with in_valid && in_ready.
//  - Accept edge: latch kernel, window and kernel_err; clear acc and wsum; set idx=0; go to MAC.
//  - MAC: one tap per cycle, row-major (idx = r*SIZE+c).
//    acc += k*p, with an 8x8 -> 16-bit product, zero-extended to ACC_W. wsum += k (16 bits).
//    After idx=N-1, go to DIV. No overflow is possible at these widths.
//  - DIV entry: if wsum==0 or kernel_err, skip the divide. Go to DONE with out_err=1 and out_pixel=0.
//  - Otherwise divide dividend = acc + (wsum>>1), i.e. round half up, by divisor = wsum.
//    Use an unsigned restoring divide for exactly ACC_W cycles.
//  - DONE: out_pixel = min(quotient, 255) (saturate, defensive), out_err=0, out_valid=1.
//  - Latency: out_valid rises at the N+ACC_W+1-th edge after the accept edge; 73 edges for SIZE=7.
//    The zero-weight-sum path rises at the N+1-th edge.
//  - out_valid, out_pixel and out_err are registered and held stable while out_valid && !out_ready.
//  - The edge with out_valid && out_ready clears out_valid and returns to IDLE. The next accept is possible one cycle later.
//  - Upstream may change kernel/window freely after the accept edge; later edits have no effect.
//  - in_valid while busy is ignored. There is no queueing.
// STRUCTURE
//  - Package conv_pkg: PIX_W=8; typedef enum logic [1:0] {IDLE,MAC,DIV,DONE} conv_state_t;
//    function acc_width(size) returning 16+$clog2(size*size)+1.
//  - Sub-module seq_divider #(W): ports clk, n_rst, start, dividend[W], divisor[W], busy, done, quotient[W].
//    Restoring divider, W cycles, done is a 1-cycle pulse. Instantiated once with W=ACC_W.
//  - Top: FSM, tap index counter, MAC datapath, output registers.
// TESTING (SIZE=7 unless noted; check latency on every case)
//  1 Uniform: kernel all 1, window all 100 -> out_pixel=100, out_err=0; out_valid 73 edges after accept.
//  2 Delta: kernel[3][3]=1, all other weights 0; window[3][3]=37, all other pixels 255 -> out_pixel=37.
//  3 Zero kernel: all weights 0 -> out_err=1, out_pixel=0, out_valid 50 edges after accept.
//    Repeat with a valid kernel and kernel_err=1 -> same response.
//  4 Rounding (SIZE=3): kernel {1,2,1;2,4,2;1,2,1}, window[0][0]=8, all others 0 -> acc=8, wsum=16, out_pixel=1.
//    Same kernel with window[0][0]=7 -> out_pixel=0.
//  5 Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0.
//    Then out_ready=1 -> handshake, in_ready=1 next cycle. Back-to-back second transaction is correct.
//  6 Reset mid-MAC: n_rst=0 for one edge at accept+20 -> out_valid=0, in_ready=1 after the reset edge.
//    No stale output appears. A fresh case-1 transaction returns 100.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the kernel convolution MAC.
// Contents: pixel width, FSM state encoding, accumulator width function.
// Imported by kernel_conv_mac; seq_divider is width-parameterised and self-contained.
package conv_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } conv_state_t;

  // 16-bit products summed over size*size taps, plus one bit of headroom
  // for the rounding bias added before the divide.
  function automatic int acc_width(input int size);
    return 16 + $clog2(size * size) + 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W cycles per divide.
// Ports: clk, n_rst (sync, active-low), start (1-cycle launch), dividend/divisor (sampled on start),
//        busy (iterations pending), done (1-cycle pulse when quotient is final), quotient.
module seq_divider #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W:0]       rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     dsor;
  logic [CNT_W-1:0] cnt;

  logic [W:0]       src_rem;
  logic [W-1:0]     src_quo;
  logic [W-1:0]     use_dsor;
  logic [W:0]       shifted;
  logic [W:0]       diff;
  logic             fits;

  // The start cycle already performs the first iteration straight from the
  // input operands, so the whole divide occupies exactly W edges.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_quo  = start ? dividend : quo;
    use_dsor = start ? divisor : dsor;
    shifted  = {src_rem[W-1:0], src_quo[W-1]};
    diff     = shifted - {1'b0, use_dsor};
    fits     = (shifted >= {1'b0, use_dsor});
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rem  <= '0;
      quo  <= '0;
      dsor <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || (cnt != '0)) begin
        rem <= fits ? diff : shifted;
        quo <= {src_quo[W-2:0], fits};
        if (start) begin
          dsor <= divisor;
          cnt  <= CNT_W'(W - 1);
          done <= (W == 1);
        end else begin
          cnt  <= cnt - 1'b1;
          done <= (cnt == CNT_W'(1));
        end
      end
    end
  end

  assign busy     = (cnt != '0);
  assign quotient = quo;

endmodule

// File: rtl/kernel_conv_mac.sv
// Applies a SIZE x SIZE 8-bit kernel to one pixel window: round(sum(k*p)/sum(k)), saturated to 8 bits.
// Ports: clk, n_rst (sync, active-low); kernel/kernel_err/window with in_valid/in_ready;
//        out_pixel/out_err with out_valid/out_ready. One MAC per cycle, then a 1-bit/cycle divide.
module kernel_conv_mac
  import conv_pkg::*;
#(
  parameter int SIZE = 7
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic [SIZE-1:0][SIZE-1:0][PIX_W-1:0]   kernel,
  input  logic                                   kernel_err,
  input  logic [SIZE-1:0][SIZE-1:0][PIX_W-1:0]   window,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [PIX_W-1:0]                       out_pixel,
  output logic                                   out_err,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int N      = SIZE * SIZE;
  localparam int ACC_W  = acc_width(SIZE);
  localparam int IDX_W  = $clog2(N);
  localparam int FLAT_W = N * PIX_W;

  conv_state_t       state;
  conv_state_t       state_nxt;

  // Latched taps; shifted down one byte per MAC cycle so the current tap is
  // always in the low byte (element [0][0] sits at the LSBs, giving row-major order).
  logic [FLAT_W-1:0] kern_sh;
  logic [FLAT_W-1:0] win_sh;
  logic              kerr_q;
  logic [ACC_W-1:0]  acc;
  logic [15:0]       wsum;
  logic [IDX_W-1:0]  idx;

  logic              accept;
  logic              last_tap;
  logic              div_skip;
  logic [15:0]       prod;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [ACC_W-1:0]  dividend;
  logic [ACC_W-1:0]  divisor;
  logic [ACC_W-1:0]  quotient;

  assign accept   = in_valid && in_ready;
  assign last_tap = (idx == IDX_W'(N - 1));
  assign div_skip = (wsum == '0) || kerr_q;
  assign prod     = 16'(kern_sh[PIX_W-1:0]) * 16'(win_sh[PIX_W-1:0]);
  // Adding half the divisor turns the truncating divide into round-half-up.
  assign dividend = acc + ACC_W'(wsum >> 1);
  assign divisor  = ACC_W'(wsum);

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)                state_nxt = MAC;
      MAC:  if (last_tap)              state_nxt = DIV;
      DIV:  if (div_skip || div_done)  state_nxt = DONE;
      DONE: if (out_ready)             state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // FSM outputs. The divider is launched on the first DIV cycle only: after
  // that it is busy, and on its done cycle the FSM leaves DIV.
  always_comb begin
    in_ready  = (state == IDLE);
    div_start = (state == DIV) && !div_skip && !div_busy && !div_done;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      kern_sh   <= '0;
      win_sh    <= '0;
      kerr_q    <= 1'b0;
      acc       <= '0;
      wsum      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_pixel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            kern_sh <= kernel;
            win_sh  <= window;
            kerr_q  <= kernel_err;
            acc     <= '0;
            wsum    <= '0;
            idx     <= '0;
          end
        end
        MAC: begin
          acc     <= acc + ACC_W'(prod);
          wsum    <= wsum + 16'(kern_sh[PIX_W-1:0]);
          kern_sh <= kern_sh >> PIX_W;
          win_sh  <= win_sh >> PIX_W;
          idx     <= idx + 1'b1;
        end
        DIV: begin
          if (div_skip) begin
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_pixel <= '0;
          end else if (div_done) begin
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            // Cannot exceed 255 for a true weighted average; clamp anyway.
            out_pixel <= (quotient > ACC_W'(255)) ? 8'hFF : quotient[PIX_W-1:0];
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  seq_divider #(
    .W (ACC_W)
  ) u_div (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_kernel_conv_mac.sv
// Self-checking bench for kernel_conv_mac: directed cases plus randomized transactions against
// an arithmetic reference model. Two instances: SIZE=7 (main) and SIZE=3 (rounding cases).
// Latency is measured from the accept edge to the first edge where out_valid is seen high.
module tb_kernel_conv_mac;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // SIZE=7 instance
  logic [6:0][6:0][7:0] k7, w7;
  logic kerr7, iv7, ir7, ov7, oe7, ordy7;
  logic [7:0] op7;

  // SIZE=3 instance
  logic [2:0][2:0][7:0] k3, w3;
  logic kerr3, iv3, ir3, ov3, oe3, ordy3;
  logic [7:0] op3;

  int n_cmp = 0;
  int n_bad = 0;

  kernel_conv_mac #(.SIZE(7)) dut7 (
    .clk(clk), .n_rst(n_rst), .kernel(k7), .kernel_err(kerr7), .window(w7),
    .in_valid(iv7), .in_ready(ir7), .out_pixel(op7), .out_err(oe7),
    .out_valid(ov7), .out_ready(ordy7)
  );

  kernel_conv_mac #(.SIZE(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .kernel(k3), .kernel_err(kerr3), .window(w3),
    .in_valid(iv3), .in_ready(ir3), .out_pixel(op3), .out_err(oe3),
    .out_valid(ov3), .out_ready(ordy3)
  );

  // Reference: weighted average with round-half-up, error on zero weight sum or kernel error.
  function automatic void model(input int sz, input logic [1799:0] kf, input logic [1799:0] wf,
                                input logic kerr, output int pix, output logic err, output int lat);
    int acc;
    int ws;
    acc = 0;
    ws  = 0;
    for (int i = 0; i < sz * sz; i++) begin
      acc += int'(kf[i*8 +: 8]) * int'(wf[i*8 +: 8]);
      ws  += int'(kf[i*8 +: 8]);
    end
    if (ws == 0 || kerr) begin
      pix = 0;
      err = 1'b1;
      lat = sz * sz + 1;
    end else begin
      pix = (2 * acc + ws) / (2 * ws);
      if (pix > 255) pix = 255;
      err = 1'b0;
      lat = sz * sz + (16 + $clog2(sz * sz) + 1) + 1;
    end
  endfunction

  // Drives one SIZE=7 transaction with out_ready held high; returns what the DUT produced.
  // Inputs are scrambled right after the accept edge to show they are not re-read.
  task automatic run7(input logic [6:0][6:0][7:0] k, input logic [6:0][6:0][7:0] w, input logic e,
                      output int lat, output logic [7:0] pix, output logic err);
    k7 = k; w7 = w; kerr7 = e; iv7 = 1'b1; ordy7 = 1'b1;
    @(posedge clk); #1;
    iv7 = 1'b0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        k7[r][c] = 8'($urandom);
        w7[r][c] = 8'($urandom);
      end
    kerr7 = 1'($urandom);
    lat = -1; pix = 8'h00; err = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (ov7) begin
        lat = i; pix = op7; err = oe7;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run3(input logic [2:0][2:0][7:0] k, input logic [2:0][2:0][7:0] w, input logic e,
                      output int lat, output logic [7:0] pix, output logic err);
    k3 = k; w3 = w; kerr3 = e; iv3 = 1'b1; ordy3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        k3[r][c] = 8'($urandom);
        w3[r][c] = 8'($urandom);
      end
    lat = -1; pix = 8'h00; err = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (ov3) begin
        lat = i; pix = op3; err = oe3;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    iv7 = 1'b0; ordy7 = 1'b1; kerr7 = 1'b0; k7 = '0; w7 = '0;
    iv3 = 1'b0; ordy3 = 1'b1; kerr3 = 1'b0; k3 = '0; w3 = '0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    n_cmp++; if (ir7 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", ir7); end
    n_cmp++; if (ov7 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", ov7); end
    n_cmp++; if (oe7 !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got=%b want=0", oe7); end
    n_cmp++; if (op7 !== 8'd0) begin n_bad++; $display("FAIL reset_out_pixel got=%0d want=0", op7); end
    n_cmp++; if (ir3 !== 1'b1 || ov3 !== 1'b0) begin n_bad++;
      $display("FAIL reset_size3 got in_ready=%b out_valid=%b want 1/0", ir3, ov3); end
  endtask

  task automatic test_uniform();
    logic [6:0][6:0][7:0] k, w;
    int lat; logic [7:0] pix; logic err;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin k[r][c] = 8'd1; w[r][c] = 8'd100; end
    run7(k, w, 1'b0, lat, pix, err);
    n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL uniform_latency got=%0d want=73", lat); end
    n_cmp++; if (pix !== 8'd100) begin n_bad++; $display("FAIL uniform_pixel got=%0d want=100", pix); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL uniform_err got=%b want=0", err); end
    n_cmp++; if (ir7 !== 1'b1 || ov7 !== 1'b0) begin n_bad++;
      $display("FAIL uniform_after_handshake got in_ready=%b out_valid=%b want 1/0", ir7, ov7); end
  endtask

  task automatic test_delta();
    logic [6:0][6:0][7:0] k, w;
    int lat; logic [7:0] pix; logic err;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin k[r][c] = 8'd0; w[r][c] = 8'd255; end
    k[3][3] = 8'd1; w[3][3] = 8'd37;
    run7(k, w, 1'b0, lat, pix, err);
    n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL delta_latency got=%0d want=73", lat); end
    n_cmp++; if (pix !== 8'd37 || err !== 1'b0) begin n_bad++;
      $display("FAIL delta_pixel got=%0d err=%b want=37 err=0", pix, err); end
  endtask

  task automatic test_zero_kernel();
    logic [6:0][6:0][7:0] k, w;
    int lat; logic [7:0] pix; logic err;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin k[r][c] = 8'd0; w[r][c] = 8'($urandom); end
    run7(k, w, 1'b0, lat, pix, err);
    n_cmp++; if (lat !== 50) begin n_bad++; $display("FAIL zero_kernel_latency got=%0d want=50", lat); end
    n_cmp++; if (err !== 1'b1 || pix !== 8'd0) begin n_bad++;
      $display("FAIL zero_kernel_result got err=%b pix=%0d want err=1 pix=0", err, pix); end
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) k[r][c] = 8'd1 + 8'($urandom_range(0, 9));
    run7(k, w, 1'b1, lat, pix, err);
    n_cmp++; if (lat !== 50) begin n_bad++; $display("FAIL kernel_err_latency got=%0d want=50", lat); end
    n_cmp++; if (err !== 1'b1 || pix !== 8'd0) begin n_bad++;
      $display("FAIL kernel_err_result got err=%b pix=%0d want err=1 pix=0", err, pix); end
  endtask

  task automatic test_rounding();
    logic [2:0][2:0][7:0] k, w;
    int lat; logic [7:0] pix; logic err;
    int epix; logic eerr; int elat;
    k[0][0] = 8'd1; k[0][1] = 8'd2; k[0][2] = 8'd1;
    k[1][0] = 8'd2; k[1][1] = 8'd4; k[1][2] = 8'd2;
    k[2][0] = 8'd1; k[2][1] = 8'd2; k[2][2] = 8'd1;
    w = '0; w[0][0] = 8'd8;
    run3(k, w, 1'b0, lat, pix, err);
    n_cmp++; if (lat !== 31) begin n_bad++; $display("FAIL round_up_latency got=%0d want=31", lat); end
    n_cmp++; if (pix !== 8'd1 || err !== 1'b0) begin n_bad++;
      $display("FAIL round_up_pixel got=%0d err=%b want=1 err=0", pix, err); end
    w[0][0] = 8'd7;
    run3(k, w, 1'b0, lat, pix, err);
    n_cmp++; if (pix !== 8'd0 || lat !== 31) begin n_bad++;
      $display("FAIL round_down_pixel got=%0d lat=%0d want=0 lat=31", pix, lat); end
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          k[r][c] = 8'($urandom_range(0, 255));
          w[r][c] = 8'($urandom);
        end
      model(3, 1800'(k), 1800'(w), 1'b0, epix, eerr, elat);
      run3(k, w, 1'b0, lat, pix, err);
      n_cmp++; if (lat !== elat || int'(pix) !== epix || err !== eerr) begin n_bad++;
        $display("FAIL random3_%0d got pix=%0d err=%b lat=%0d want pix=%0d err=%b lat=%0d",
                 t, pix, err, lat, epix, eerr, elat); end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0][6:0][7:0] k, w;
    int lat; logic [7:0] pix; logic err;
    int epix; logic eerr; int elat;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        k[r][c] = 8'($urandom_range(0, 40));
        w[r][c] = 8'($urandom);
      end
    k[0][0] = 8'd5;
    model(7, 1800'(k), 1800'(w), 1'b0, epix, eerr, elat);
    k7 = k; w7 = w; kerr7 = 1'b0; iv7 = 1'b1; ordy7 = 1'b0;
    @(posedge clk); #1;
    iv7 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (ov7) begin lat = i; break; end
    end
    n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, elat); end
    // Offer a different transaction while busy; it must be ignored.
    k7 = '0; kerr7 = 1'b1; iv7 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (ov7 !== 1'b1 || int'(op7) !== epix || oe7 !== eerr || ir7 !== 1'b0) begin n_bad++;
        $display("FAIL bp_hold_%0d got valid=%b pix=%0d err=%b in_ready=%b want 1/%0d/%b/0",
                 i, ov7, op7, oe7, ir7, epix, eerr); end
    end
    iv7 = 1'b0; ordy7 = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ov7 !== 1'b0 || ir7 !== 1'b1) begin n_bad++;
      $display("FAIL bp_release got valid=%b in_ready=%b want 0/1", ov7, ir7); end
    // Back-to-back second transaction
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        k[r][c] = 8'($urandom_range(1, 255));
        w[r][c] = 8'($urandom);
      end
    model(7, 1800'(k), 1800'(w), 1'b0, epix, eerr, elat);
    run7(k, w, 1'b0, lat, pix, err);
    n_cmp++; if (lat !== elat || int'(pix) !== epix || err !== eerr) begin n_bad++;
      $display("FAIL bp_second got pix=%0d err=%b lat=%0d want pix=%0d err=%b lat=%0d",
               pix, err, lat, epix, eerr, elat); end
  endtask

  task automatic test_reset_mid_mac();
    logic [6:0][6:0][7:0] k, w;
    int lat; logic [7:0] pix; logic err;
    int stale;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin k[r][c] = 8'd3; w[r][c] = 8'd200; end
    k7 = k; w7 = w; kerr7 = 1'b0; iv7 = 1'b1; ordy7 = 1'b1;
    @(posedge clk); #1;
    iv7 = 1'b0;
    repeat (19) @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    n_cmp++; if (ov7 !== 1'b0 || ir7 !== 1'b1) begin n_bad++;
      $display("FAIL midreset_state got valid=%b in_ready=%b want 0/1", ov7, ir7); end
    stale = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ov7) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL midreset_stale got=%0d valid cycles want=0", stale); end
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin k[r][c] = 8'd1; w[r][c] = 8'd100; end
    run7(k, w, 1'b0, lat, pix, err);
    n_cmp++; if (lat !== 73 || pix !== 8'd100 || err !== 1'b0) begin n_bad++;
      $display("FAIL midreset_fresh got pix=%0d err=%b lat=%0d want 100/0/73", pix, err, lat); end
  endtask

  task automatic test_random();
    logic [6:0][6:0][7:0] k, w;
    int lat; logic [7:0] pix; logic err;
    int epix; logic eerr; int elat;
    logic e;
    for (int t = 0; t < 20; t++) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++) begin
          k[r][c] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
          w[r][c] = 8'($urandom);
        end
      if (t % 7 == 3) k = '0;
      e = ($urandom_range(0, 9) == 0);
      model(7, 1800'(k), 1800'(w), e, epix, eerr, elat);
      run7(k, w, e, lat, pix, err);
      n_cmp++; if (lat !== elat || int'(pix) !== epix || err !== eerr) begin n_bad++;
        $display("FAIL random7_%0d got pix=%0d err=%b lat=%0d want pix=%0d err=%b lat=%0d",
                 t, pix, err, lat, epix, eerr, elat); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_uniform();
    test_delta();
    test_zero_kernel();
    test_rounding();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
